rev_mod: RTL
============

// Module: rev_mod
// PURPOSE
//  Reverse-order word-index sequencer for AES inverse key expansion / decryption.
//  It is the decrypt-side counterpart of the forward key-schedule counter.
//  It walks word index i downward from Nw-1 to Nk and flags the words that need RotWord/SubWord/Rcon.
//  It also provides the Rcon value for each such word, generated backwards in GF(2^8).
//  Sits between the key register file and the inverse key-expansion datapath.
//  Uses a valid/ready handshake.
// PARAMETERS
//  IW      6    width of i_out; must be >= 6 (max index 59)
// PORTS
//  clk_in        in   1   clock, rising edge
//  rst_in        in   1   asynchronous, active-low reset
//  enable_in     in   1   level: start (IDLE) / keep running; low aborts
//  conf_in       in   2   0=AES-128 (Nk4,Nw44) 1=AES-192 (Nk6,Nw52) 2=AES-256 (Nk8,Nw60) 3=treated as 0
//  ready_in      in   1   consumer accepts current word
//  valid_out     out  1   current index outputs valid
//  i_out         out  IW  word index i
//  imodk_out     out  3   i mod Nk
//  nw_imodk_out  out  1   i mod Nk == 0 (RotWord+SubWord+Rcon word)
//  sub_only_out  out  1   AES-256 only: i mod 8 == 4 (SubWord only)
//  rcon_out      out  8   Rcon for i/Nk; meaningful when nw_imodk_out=1
//  last_out      out  1   valid_out && i == Nk
//  done_out      out  1   sequence complete, high in DONE
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE.
//  - All outputs 0: i_out=0, imodk_out=0, rcon_out=8'h00, valid_out=0, done_out=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: on a rising edge with enable_in=1:
//  - latch conf_in (later conf_in changes ignored until the next IDLE);
//  - load i=Nw-1 (43/51/59) and imodk=3 (always 3 for all key sizes);
//  - load rcon = 8'h36 / 8'h80 / 8'h40 for conf 0/1/2;
//  - enter RUN. valid_out is high the cycle after enable_in is sampled.
//  RUN: transfer = valid_out && ready_in.
//  - No transfer: every output holds stable.
//  - Transfer with i != Nk:
//    - i <= i-1;
//    - imodk <= (imodk==0) ? Nk-1 : imodk-1;
//    - if imodk==0: rcon <= rcon[0] ? (rcon>>1)^8'h8D : rcon>>1 (multiply by x^-1 mod 0x11B).
//  - Transfer with i == Nk (last_out=1): go to DONE.
//  - enable_in=0 in RUN: abort to IDLE on the next edge.
//    - An accepted transfer in that same cycle still counts; valid_out=0 afterwards.
//  DONE: valid_out=0, done_out=1; i_out, imodk_out and rcon_out hold their final values.
//  - Return to IDLE when enable_in=0.
//  - While enable_in stays 1, stay in DONE (no auto-restart).
//  Combinational outputs from registered state:
//  - nw_imodk_out = valid_out && imodk==0;
//  - sub_only_out = valid_out && conf==2 && imodk==4;
//  - last_out = valid_out && i==Nk.
//  The last word (i=Nk) always has imodk=0 and rcon_out=8'h01.
//  Word counts per run: 40 / 46 / 52 for conf 0/1/2.
//  Reset asserted mid-RUN: immediate return to reset values; no partial word is flagged.
// TESTING
//  T1: conf=0, ready=1 -> 40 transfers.
//      - First word i=43, imodk=3; i=40: nw=1, rcon=36.
//      - i=36: rcon=1B; i=8: rcon=02.
//      - Last word i=4: rcon=01, last_out=1; then done_out=1.
//  T2: conf=1, ready=1 -> 46 transfers.
//      - i=51 imodk=3; i=48: nw=1, rcon=80; i=42: rcon=40.
//      - Last word i=6: rcon=01.
//  T3: conf=2, ready=1 -> 52 transfers.
//      - i=56: nw=1, rcon=40; i=52: sub_only=1, nw=0.
//      - Last word i=8: rcon=01; sub_only_out never high for conf 0/1.
//  T4: conf=0, ready toggled randomly -> outputs stable while ready=0.
//      - Sequence identical to T1; exactly one last_out transfer.
//  T5: abort and reset during RUN.
//      - Drop enable_in at i=30: valid_out=0 next cycle, FSM in IDLE.
//      - Re-enable: restart at i=43.
//      - Pulse rst_in low mid-run: all outputs 0 immediately.
//  T6: conf=3 -> identical to T1.
//      - Change conf_in to 2 mid-run -> sequence unaffected.

Source files
------------

// File: rtl/rev_mod.sv
// rev_mod: reverse-order word-index sequencer for AES inverse key expansion.
// Walks word index i from Nw-1 down to Nk, flags words needing
// RotWord/SubWord/Rcon, and produces the Rcon value by stepping backwards
// through GF(2^8) (multiplication by x^-1 modulo 0x11B).
module rev_mod #(
    parameter int IW = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          enable_in,
    input  logic [1:0]    conf_in,
    input  logic          ready_in,
    output logic          valid_out,
    output logic [IW-1:0] i_out,
    output logic [2:0]    imodk_out,
    output logic          nw_imodk_out,
    output logic          sub_only_out,
    output logic [7:0]    rcon_out,
    output logic          last_out,
    output logic          done_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reduction polynomial 0x11B shifted right by one: the value folded back in
    // when a set LSB is shifted out during division by x.
    localparam logic [7:0] RCON_POLY = 8'h8D;

    state_t          state_reg, state_next;
    logic [1:0]      conf_reg, conf_next;
    logic [IW-1:0]   i_reg, i_next;
    logic [2:0]      imodk_reg, imodk_next;
    logic [7:0]      rcon_reg, rcon_next;

    logic [1:0]      conf_eff;
    logic [IW-1:0]   start_i;
    logic [7:0]      start_rcon;
    logic [IW-1:0]   nk_val;
    logic [2:0]      nk_m1;
    logic [7:0]      rcon_step;
    logic            transfer;
    logic            at_last;

    // Key size 3 is an alias of AES-128; normalise it once at load time.
    assign conf_eff = (conf_in == 2'd3) ? 2'd0 : conf_in;

    // Starting index and Rcon for the top word of each key schedule.
    always_comb begin
        start_i    = IW'(43);
        start_rcon = 8'h36;
        case (conf_eff)
            2'd1: begin
                start_i    = IW'(51);
                start_rcon = 8'h80;
            end
            2'd2: begin
                start_i    = IW'(59);
                start_rcon = 8'h40;
            end
            default: begin
                start_i    = IW'(43);
                start_rcon = 8'h36;
            end
        endcase
    end

    // Nk of the latched key size, both as an index-width value and as Nk-1
    // for the modulo counter wrap.
    always_comb begin
        nk_val = IW'(4);
        nk_m1  = 3'd3;
        case (conf_reg)
            2'd1: begin
                nk_val = IW'(6);
                nk_m1  = 3'd5;
            end
            2'd2: begin
                nk_val = IW'(8);
                nk_m1  = 3'd7;
            end
            default: begin
                nk_val = IW'(4);
                nk_m1  = 3'd3;
            end
        endcase
    end

    // Rcon / x in GF(2^8): shift right, fold the polynomial in if bit 0 was set.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_rcon_step
            assign rcon_step[gi] = rcon_reg[gi+1] ^ (rcon_reg[0] & RCON_POLY[gi]);
        end
    endgenerate
    assign rcon_step[7] = rcon_reg[0] & RCON_POLY[7];

    assign transfer = valid_out && ready_in;
    assign at_last  = (i_reg == nk_val);

    // State and sequencing registers; asynchronous reset clears every output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= ST_IDLE;
            conf_reg  <= 2'd0;
            i_reg     <= '0;
            imodk_reg <= 3'd0;
            rcon_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            conf_reg  <= conf_next;
            i_reg     <= i_next;
            imodk_reg <= imodk_next;
            rcon_reg  <= rcon_next;
        end
    end

    // Next-state logic: load on start, step down on each accepted word,
    // abort back to IDLE whenever enable drops during a run.
    always_comb begin
        state_next = state_reg;
        conf_next  = conf_reg;
        i_next     = i_reg;
        imodk_next = imodk_reg;
        rcon_next  = rcon_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable_in) begin
                    conf_next  = conf_eff;
                    i_next     = start_i;
                    imodk_next = 3'd3;
                    rcon_next  = start_rcon;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    if (at_last) begin
                        state_next = ST_DONE;
                    end else begin
                        i_next     = i_reg - IW'(1);
                        imodk_next = (imodk_reg == 3'd0) ? nk_m1 : imodk_reg - 3'd1;
                        if (imodk_reg == 3'd0) begin
                            rcon_next = rcon_step;
                        end
                    end
                end
                // An accepted word in this cycle is still applied above.
                if (!enable_in) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!enable_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign valid_out    = (state_reg == ST_RUN);
    assign done_out     = (state_reg == ST_DONE);
    assign i_out        = i_reg;
    assign imodk_out    = imodk_reg;
    assign rcon_out     = rcon_reg;
    assign nw_imodk_out = valid_out && (imodk_reg == 3'd0);
    assign sub_only_out = valid_out && (conf_reg == 2'd2) && (imodk_reg == 3'd4);
    assign last_out     = valid_out && at_last;

endmodule
